// File: rtl/axi_pkg.sv
// Shared AXI write-side types and constants for the SRAM slave front ends.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_RESP  = 2'b10
    } wstate_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Word pointer for one AXI burst: loads on AW accept, steps per W beat
// according to FIXED/INCR/WRAP, and flags WRAP lengths that are not 2/4/8/16.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic                  adv_i,
    input  logic [3:0]            len_i,
    input  burst_t                burst_i,
    input  logic [3:0]            aw_len_i,
    input  burst_t                aw_burst_i,
    output logic [ADDR_WIDTH-1:0] ptr_o,
    output logic                  wrap_err_o
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [ADDR_WIDTH-1:0] ptr_inc;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    // For legal WRAP lengths AWLEN is (window words - 1), i.e. the low-bit mask.
    assign wrap_mask = {{(ADDR_WIDTH-4){1'b0}}, len_i};
    assign ptr_inc   = ptr_q + ADDR_WIDTH'(1);

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_addr_i;
        end else if (adv_i) begin
            case (burst_i)
                BURST_INCR: ptr_d = ptr_inc;
                BURST_WRAP: ptr_d = (ptr_q & ~wrap_mask) | (ptr_inc & wrap_mask);
                default:    ptr_d = ptr_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o      = ptr_q;
    assign wrap_err_o = (aw_burst_i == BURST_WRAP) &&
                        (aw_len_i != 4'd1) && (aw_len_i != 4'd3) &&
                        (aw_len_i != 4'd7) && (aw_len_i != 4'd15);

endmodule

// File: rtl/axi_sram_write_slave.sv
// AXI write slave in front of a word-wide SRAM: one burst at a time, byte-masked
// zero-latency write strobes per W beat, single B response per burst.
module axi_sram_write_slave
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [31:0]             AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_di,
    output logic                    w_busy
);

    wstate_t               state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [3:0]            len_q, len_d;
    burst_t                burst_q, burst_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  ptr_load;
    logic                  ptr_adv;
    logic                  wrap_err;
    logic                  w_hs;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  unused_bits;

    // Byte offset, upper address bits and AWSIZE carry no information for a word-only SRAM.
    assign unused_bits = (^{AWADDR[31:ADDR_WIDTH+2], AWADDR[1:0]}) ^ (AWSIZE != SIZE_WORD);

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ptr_load),
        .load_addr_i (AWADDR[ADDR_WIDTH+1:2]),
        .adv_i       (ptr_adv),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .aw_len_i    (AWLEN),
        .aw_burst_i  (burst_t'(AWBURST)),
        .ptr_o       (ptr),
        .wrap_err_o  (wrap_err)
    );

    assign w_hs      = WVALID && (state_q == ST_WRITE);
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        len_d    = len_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        ptr_load = 1'b0;
        ptr_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AWVALID) begin
                    id_d     = AWID;
                    len_d    = AWLEN;
                    burst_d  = burst_t'(AWBURST);
                    cnt_d    = '0;
                    err_d    = (AWBURST == BURST_RSVD) || wrap_err;
                    ptr_load = 1'b1;
                    state_d  = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_hs) begin
                    ptr_adv = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    // Whichever of WLAST / beat count comes first closes the burst.
                    if (WLAST || last_beat) begin
                        err_d   = err_q | (WLAST != last_beat);
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q   <= len_d;
        burst_q <= burst_d;
    end

    assign AWREADY  = (state_q == ST_IDLE);
    assign WREADY   = (state_q == ST_WRITE);
    assign BVALID   = (state_q == ST_RESP);
    assign BID      = id_q;
    assign BRESP    = err_q ? RESP_SLVERR : RESP_OKAY;
    assign w_busy   = (state_q != ST_IDLE);
    assign mem_we   = (w_hs && !err_q) ? WSTRB : '0;
    assign mem_addr = ptr;
    assign mem_di   = WDATA;

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Randomized and directed stimulus for axi_sram_write_slave, checked against a
// transaction-level model of pointer sequencing, strobes and responses.
module tb_axi_sram_write_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = 3'b010;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_di;
    logic        w_busy;

    axi_sram_write_slave #(
        .ID_WIDTH   (8),
        .ADDR_WIDTH (14),
        .DATA_WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .AWID     (AWID),
        .AWADDR   (AWADDR),
        .AWLEN    (AWLEN),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BID      (BID),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .w_busy   (w_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model of the burst in flight
    int          m_ptr;
    int          m_len;
    int          m_burst;
    int          m_cnt;
    bit          m_err;
    logic [7:0]  m_id;

    bit          use_tab = 1'b0;
    logic [31:0] data_tab [16];
    logic [3:0]  strb_tab [16];

    function automatic int next_ptr(input int p);
        int w;
        int base;
        case (m_burst)
            1: return (p + 1) % 16384;
            2: begin
                w    = m_len + 1;
                base = p - (p % w);
                return base + ((p + 1 - base) % w);
            end
            default: return p;
        endcase
    endfunction

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input int len, input int burst);
        AWID    = id;
        AWADDR  = addr;
        AWLEN   = len[3:0];
        AWBURST = burst[1:0];
        AWSIZE  = 3'b010;
        AWVALID = 1'b1;
        @(negedge clk);
        chk("aw_ready", AWREADY, 1);
        chk("busy_idle", w_busy, 0);
        chk("wready_idle", WREADY, 0);
        @(posedge clk);
        #1;
        AWVALID = 1'b0;
        m_id    = id;
        m_len   = len;
        m_burst = burst;
        m_cnt   = 0;
        m_ptr   = int'(addr[15:2]);
        m_err   = (burst == 3) ||
                  (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input bit last,
                          input int gap, output bit done);
        bit fin;
        for (int g = 0; g < gap; g++) begin
            WVALID = 1'b0;
            @(negedge clk);
            chk("wready_gap", WREADY, 1);
            chk("we_gap", mem_we, 0);
            @(posedge clk);
            #1;
        end
        WVALID = 1'b1;
        WDATA  = data;
        WSTRB  = strb;
        WLAST  = last;
        @(negedge clk);
        chk("wready_beat", WREADY, 1);
        chk("busy_write", w_busy, 1);
        chk("mem_we", mem_we, m_err ? 4'b0000 : strb);
        if (!m_err) begin
            chk("mem_addr", mem_addr, m_ptr);
            chk("mem_di", mem_di, data);
        end
        fin  = (m_cnt == m_len);
        done = last || fin;
        if (done && (last != fin)) m_err = 1'b1;
        m_ptr = next_ptr(m_ptr);
        m_cnt++;
        @(posedge clk);
        #1;
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic b_phase(input int dly);
        AWVALID = (dly > 0);
        AWID    = 8'hEE;
        AWADDR  = $urandom;
        for (int d = 0; d <= dly; d++) begin
            if (d == dly) begin
                BREADY  = 1'b1;
                AWVALID = 1'b0;
            end
            @(negedge clk);
            chk("bvalid", BVALID, 1);
            chk("bid", BID, m_id);
            chk("bresp", BRESP, m_err ? 2'b10 : 2'b00);
            chk("awready_resp", AWREADY, 0);
            chk("wready_resp", WREADY, 0);
            chk("we_resp", mem_we, 0);
            @(posedge clk);
            #1;
        end
        BREADY = 1'b0;
        @(negedge clk);
        chk("bvalid_drop", BVALID, 0);
        chk("awready_back", AWREADY, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                             input int burst, input int wl, input int gapmax, input int dly);
        bit          done;
        int          i;
        logic [31:0] data;
        logic [3:0]  strb;
        aw_send(id, addr, len, burst);
        done = 1'b0;
        i    = 0;
        while (!done) begin
            data = use_tab ? data_tab[i] : $urandom;
            strb = use_tab ? strb_tab[i] : 4'($urandom_range(0, 15));
            w_beat(data, strb, (i == wl), $urandom_range(0, gapmax), done);
            i++;
        end
        b_phase(dly);
    endtask

    initial begin
        bit d;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_awready", AWREADY, 1);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_bid", BID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", w_busy, 0);
        @(posedge clk);
        #1;

        // Single beat
        use_tab = 1'b1;
        data_tab[0] = 32'hDEADBEEF;
        strb_tab[0] = 4'b1111;
        run_burst(8'h5A, 32'h0000_0010, 0, 1, 0, 0, 0);

        // INCR, 4 beats with gaps and mixed strobes
        strb_tab[0] = 4'b0001; strb_tab[1] = 4'b0011;
        strb_tab[2] = 4'b1111; strb_tab[3] = 4'b0000;
        for (int k = 0; k < 4; k++) data_tab[k] = 32'h1111_0000 + k;
        run_burst(8'h21, 32'h0000_0020, 3, 1, 3, 2, 0);
        use_tab = 1'b0;

        // WRAP and FIXED
        run_burst(8'h33, 32'h0000_0038, 3, 2, 3, 0, 1);
        run_burst(8'h44, 32'h0000_0100, 2, 0, 2, 1, 0);

        // Early WLAST, then a clean burst
        run_burst(8'h55, 32'h0000_0200, 3, 1, 1, 0, 0);
        run_burst(8'h56, 32'h0000_0300, 1, 1, 1, 0, 0);

        // Reserved burst type with B back-pressure
        run_burst(8'h66, 32'h0000_0400, 1, 3, 1, 0, 5);

        // Missing WLAST, illegal WRAP length, INCR pointer wrap-around
        run_burst(8'h77, 32'h0000_0500, 2, 1, 16, 0, 0);
        run_burst(8'h78, 32'h0000_0600, 2, 2, 2, 0, 0);
        run_burst(8'h79, 32'h0000_FFFC, 1, 1, 1, 0, 0);

        // Reset mid-burst on beat 2 of 4
        aw_send(8'h88, 32'h0000_0800, 3, 1);
        w_beat($urandom, 4'hF, 1'b0, 0, d);
        w_beat($urandom, 4'hF, 1'b0, 0, d);
        WVALID = 1'b1;
        WSTRB  = 4'hF;
        WDATA  = $urandom;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_awready", AWREADY, 1);
        chk("mid_rst_bvalid", BVALID, 0);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_wready", WREADY, 0);
        chk("mid_rst_busy", w_busy, 0);
        @(posedge clk);
        #1;
        WVALID = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_no_b", BVALID, 0);
            @(posedge clk);
            #1;
        end
        run_burst(8'h89, 32'h0000_0900, 1, 1, 1, 0, 0);

        // Randomized bursts
        for (int n = 0; n < 40; n++) begin
            int b;
            int l;
            int w;
            b = $urandom_range(0, 3);
            l = $urandom_range(0, 15);
            w = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 16) : l;
            run_burst(8'($urandom), $urandom, l, b, w, 2, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
